// File: rtl/load_store_unit_if.sv
// CPU request/response and bus-master signal bundle for load_store_unit.
// slave modport = the LSU; master modport = the CPU plus bus_master side.
interface load_store_unit_if #(
    parameter int TAG_W = 5
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_we_i;
    logic [1:0]       req_size_i;
    logic             req_signed_i;
    logic [31:0]      req_addr_i;
    logic [31:0]      req_wdata_i;
    logic [TAG_W-1:0] req_tag_i;

    logic             rsp_valid_o;
    logic [31:0]      rsp_data_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic             rsp_err_o;
    logic [1:0]       rsp_cause_o;

    logic             bus_en_o;
    logic             bus_we_o;
    logic [31:0]      bus_addr_o;
    logic [31:0]      bus_data_o;
    logic [3:0]       bus_mask_o;
    logic [31:0]      bus_data_i;
    logic             bus_valid_i;
    logic             bus_stall_i;
    logic             bus_err_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i, req_tag_i,
        output req_ready_o,
        output rsp_valid_o, rsp_data_o, rsp_tag_o, rsp_err_o, rsp_cause_o,
        output bus_en_o, bus_we_o, bus_addr_o, bus_data_o, bus_mask_o,
        input  bus_data_i, bus_valid_i, bus_stall_i, bus_err_i
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i, req_tag_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_data_o, rsp_tag_o, rsp_err_o, rsp_cause_o,
        input  bus_en_o, bus_we_o, bus_addr_o, bus_data_o, bus_mask_o,
        output bus_data_i, bus_valid_i, bus_stall_i, bus_err_i
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request in flight, word-aligned byte-masked bus access, 3-cycle best case, bus stall holds REQ.
// Misaligned requests answered next cycle without bus traffic; optional RESP timeout under LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int TAG_W          = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    load_store_unit_if.slave      lsu
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             lat_we;
    logic [1:0]       lat_size;
    logic             lat_sgn;
    logic [1:0]       lat_off;
    logic [TAG_W-1:0] lat_tag;

    logic             bus_we;
    logic [31:0]      bus_addr;
    logic [31:0]      bus_data;
    logic [3:0]       bus_mask;

    logic             rsp_valid;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic [1:0]       rsp_cause;

    logic             accept;
    logic             misaligned;
    logic             resp_hit;
    logic             timeout_hit;
    logic [31:0]      lane;
    logic [31:0]      load_data;
    logic [3:0]       req_mask;
    logic [31:0]      req_data;

    assign accept   = lsu.req_valid_i && (state == IDLE);
    assign resp_hit = (state == RESP) && (lsu.bus_valid_i || lsu.bus_err_i);

    always_comb begin
        misaligned = 1'b1;
        req_mask   = 4'b0000;
        req_data   = lsu.req_wdata_i;
        case (lsu.req_size_i)
            2'b00: begin
                misaligned = 1'b0;
                req_mask   = 4'b0001 << lsu.req_addr_i[1:0];
                req_data   = {4{lsu.req_wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = lsu.req_addr_i[0];
                req_mask   = 4'b0011 << lsu.req_addr_i[1:0];
                req_data   = {2{lsu.req_wdata_i[15:0]}};
            end
            2'b10: begin
                misaligned = |lsu.req_addr_i[1:0];
                req_mask   = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        lane      = lsu.bus_data_i >> {lat_off, 3'b000};
        load_data = lsu.bus_data_i;
        case (lat_size)
            2'b00:   load_data = {{24{lat_sgn & lane[7]}}, lane[7:0]};
            2'b01:   load_data = {{16{lat_sgn & lane[15]}}, lane[15:0]};
            default: load_data = lsu.bus_data_i;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Counter value N means N+1 RESP cycles have elapsed by the end of this one.
    assign timeout_hit = (state == RESP) && !(lsu.bus_valid_i || lsu.bus_err_i)
                         && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt <= 8'd0;
        end else if (state == REQ) begin
            tmo_cnt <= 8'd0;
        end else if (state == RESP) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !misaligned) state_nxt = REQ;
            REQ:     if (!lsu.bus_stall_i) state_nxt = RESP;
            RESP:    if (resp_hit || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_we    <= 1'b0;
            lat_size  <= 2'b00;
            lat_sgn   <= 1'b0;
            lat_off   <= 2'b00;
            lat_tag   <= '0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_data  <= 32'd0;
            bus_mask  <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_tag   <= '0;
            rsp_err   <= 1'b0;
            rsp_cause <= 2'b00;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                if (misaligned) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= 32'd0;
                    rsp_tag   <= lsu.req_tag_i;
                    rsp_err   <= 1'b1;
                    rsp_cause <= 2'b01;
                end else begin
                    lat_we   <= lsu.req_we_i;
                    lat_size <= lsu.req_size_i;
                    lat_sgn  <= lsu.req_signed_i;
                    lat_off  <= lsu.req_addr_i[1:0];
                    lat_tag  <= lsu.req_tag_i;
                    bus_we   <= lsu.req_we_i;
                    bus_addr <= {lsu.req_addr_i[31:2], 2'b00};
                    bus_data <= req_data;
                    bus_mask <= req_mask;
                end
            end
            // Bus error wins over a simultaneous valid.
            if (resp_hit) begin
                rsp_valid <= 1'b1;
                rsp_tag   <= lat_tag;
                if (lsu.bus_err_i) begin
                    rsp_data  <= 32'd0;
                    rsp_err   <= 1'b1;
                    rsp_cause <= 2'b10;
                end else begin
                    rsp_data  <= lat_we ? 32'd0 : load_data;
                    rsp_err   <= 1'b0;
                    rsp_cause <= 2'b00;
                end
            end else if (timeout_hit) begin
                rsp_valid <= 1'b1;
                rsp_tag   <= lat_tag;
                rsp_data  <= 32'd0;
                rsp_err   <= 1'b1;
                rsp_cause <= 2'b11;
            end
        end
    end

    assign lsu.req_ready_o = (state == IDLE);
    assign lsu.bus_en_o    = (state == REQ);
    assign lsu.bus_we_o    = bus_we;
    assign lsu.bus_addr_o  = bus_addr;
    assign lsu.bus_data_o  = bus_data;
    assign lsu.bus_mask_o  = bus_mask;
    assign lsu.rsp_valid_o = rsp_valid;
    assign lsu.rsp_data_o  = rsp_data;
    assign lsu.rsp_tag_o   = rsp_tag;
    assign lsu.rsp_err_o   = rsp_err;
    assign lsu.rsp_cause_o = rsp_cause;

endmodule
